// File: rtl/ntt_pointwise_mul.sv
// rtl/ntt_pointwise_mul.sv - NTT-domain pointwise multiply c[i] = a[i]*b[i] mod 8380417
module ntt_pointwise_mul #(
    parameter int BIT_LEN = 23,
    parameter int Q       = 8380417,
    parameter int N       = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PWM_en,
    input  logic [BIT_LEN-1:0] PWM_a_din,
    input  logic [BIT_LEN-1:0] PWM_b_din,
    output logic [7:0]         PWM_rd_addr,
    output logic               PWM_wen,
    output logic [7:0]         PWM_wr_addr,
    output logic [BIT_LEN-1:0] PWM_dout,
    output logic               PWM_busy,
    output logic               PWM_done
);

    localparam int PW = 2 * BIT_LEN;
    localparam logic [7:0] LAST = 8'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic               rv_q, rv_d;
    logic [7:0]         ra_q, ra_d;
    logic               p1_v_q, p1_v_d;
    logic [7:0]         p1_addr_q, p1_addr_d;
    logic [BIT_LEN-1:0] p1_a_q, p1_a_d;
    logic [BIT_LEN-1:0] p1_b_q, p1_b_d;
    logic               p2_v_q, p2_v_d;
    logic [7:0]         p2_addr_q, p2_addr_d;
    logic [PW-1:0]      p2_prod_q, p2_prod_d;
    logic               wen_q, wen_d;
    logic [7:0]         wr_addr_q, wr_addr_d;
    logic [BIT_LEN-1:0] dout_q, dout_d;

    logic [22:0] h1, l1, l2, l3;
    logic [36:0] f1;
    logic [13:0] h2;
    logic [27:0] f2;
    logic [4:0]  h3;
    logic [23:0] f3;
    logic [22:0] red;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rv_q      <= 1'b0;
            ra_q      <= '0;
            p1_v_q    <= 1'b0;
            p1_addr_q <= '0;
            p1_a_q    <= '0;
            p1_b_q    <= '0;
            p2_v_q    <= 1'b0;
            p2_addr_q <= '0;
            p2_prod_q <= '0;
            wen_q     <= 1'b0;
            wr_addr_q <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rv_q      <= rv_d;
            ra_q      <= ra_d;
            p1_v_q    <= p1_v_d;
            p1_addr_q <= p1_addr_d;
            p1_a_q    <= p1_a_d;
            p1_b_q    <= p1_b_d;
            p2_v_q    <= p2_v_d;
            p2_addr_q <= p2_addr_d;
            p2_prod_q <= p2_prod_d;
            wen_q     <= wen_d;
            wr_addr_q <= wr_addr_d;
            dout_q    <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (PWM_en) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST) state_d = S_DRAIN;
            S_DRAIN: if (wen_q && (wr_addr_q == LAST)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counter stops at LAST so it never wraps; cleared on the way back to IDLE.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_RUN) && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end else if (state_q == S_DONE) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        PWM_rd_addr = ((state_q == S_RUN) || (state_q == S_DRAIN)) ? cnt_q : 8'd0;
        PWM_busy    = (state_q != S_IDLE);
        PWM_done    = (state_q == S_DONE);
        PWM_wen     = wen_q;
        PWM_wr_addr = wr_addr_q;
        PWM_dout    = dout_q;
    end

    // rv/ra track the one-cycle RAM read latency so each slot carries its address.
    always_comb begin
        rv_d      = (state_q == S_RUN);
        ra_d      = cnt_q;
        p1_v_d    = rv_q;
        p1_addr_d = ra_q;
        p1_a_d    = PWM_a_din;
        p1_b_d    = PWM_b_din;
        p2_v_d    = p1_v_q;
        p2_addr_d = p1_addr_q;
        p2_prod_d = PW'(p1_a_q) * PW'(p1_b_q);
    end

    // Repeated folding with 2^23 = 2^13 - 1 (mod Q): 46 -> 37 -> 28 -> 24 bits, then < 2Q.
    always_comb begin
        h1  = p2_prod_q[45:23];
        l1  = p2_prod_q[22:0];
        f1  = 37'({h1, 13'd0}) - 37'(h1) + 37'(l1);
        h2  = f1[36:23];
        l2  = f1[22:0];
        f2  = 28'({h2, 13'd0}) - 28'(h2) + 28'(l2);
        h3  = f2[27:23];
        l3  = f2[22:0];
        f3  = 24'({h3, 13'd0}) - 24'(h3) + 24'(l3);
        red = (f3 >= 24'(Q)) ? 23'(f3 - 24'(Q)) : f3[22:0];
    end

    always_comb begin
        wen_d     = p2_v_q;
        wr_addr_d = wr_addr_q;
        dout_d    = dout_q;
        if (p2_v_q) begin
            wr_addr_d = p2_addr_q;
            dout_d    = BIT_LEN'(red);
        end
    end

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// tb/tb_ntt_pointwise_mul.sv - self-checking bench for ntt_pointwise_mul
module tb_ntt_pointwise_mul;

    localparam int Q = 8380417;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PWM_en = 1'b0;
    logic [22:0] PWM_a_din = '0;
    logic [22:0] PWM_b_din = '0;
    logic [7:0]  PWM_rd_addr;
    logic        PWM_wen;
    logic [7:0]  PWM_wr_addr;
    logic [22:0] PWM_dout;
    logic        PWM_busy;
    logic        PWM_done;

    ntt_pointwise_mul dut (
        .clk         (clk),
        .reset       (reset),
        .PWM_en      (PWM_en),
        .PWM_a_din   (PWM_a_din),
        .PWM_b_din   (PWM_b_din),
        .PWM_rd_addr (PWM_rd_addr),
        .PWM_wen     (PWM_wen),
        .PWM_wr_addr (PWM_wr_addr),
        .PWM_dout    (PWM_dout),
        .PWM_busy    (PWM_busy),
        .PWM_done    (PWM_done)
    );

    always #5 clk = ~clk;

    logic [22:0] mem_a [256];
    logic [22:0] mem_b [256];
    logic [22:0] exp_mem [256];

    always @(posedge clk) begin
        PWM_a_din <= mem_a[PWM_rd_addr];
        PWM_b_din <= mem_b[PWM_rd_addr];
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [22:0] a;
        logic [22:0] b;
        logic [22:0] c;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [22:0] mod_mul(input logic [22:0] a, input logic [22:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return 23'(p % longint'(Q));
    endfunction

    task automatic do_run(input string name, input int p1, input int p2);
        int nw;
        int ndone;
        int done_c;
        int busy_n;
        bit fin;
        nw = 0; ndone = 0; done_c = -1; busy_n = 0; fin = 0;
        @(negedge clk);
        PWM_en = 1'b1;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            PWM_en = (c == p1) || (c == p2);
            if (c == 0 || c == 255) chk($sformatf("%s rd_addr@%0d", name, c), PWM_rd_addr, c);
            if (PWM_busy) busy_n++;
            if (PWM_wen) begin
                if (nw < 256) begin
                    chk($sformatf("%s wr_addr#%0d", name, nw), PWM_wr_addr, nw);
                    chk($sformatf("%s dout[%0d]", name, nw), PWM_dout, exp_mem[nw]);
                    chk($sformatf("%s wr_cycle#%0d", name, nw), c, nw + 4);
                end else begin
                    chk($sformatf("%s extra write", name), nw, 255);
                end
                nw++;
            end
            if (PWM_done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 2) fin = 1;
        end
        PWM_en = 1'b0;
        chk($sformatf("%s write count", name), nw, 256);
        chk($sformatf("%s done count", name), ndone, 1);
        chk($sformatf("%s done cycle", name), done_c, 260);
        chk($sformatf("%s busy cycles", name), busy_n, 261);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 23'($urandom);
            mem_b[i] = 23'($urandom);
            if (i % 16 == 0) mem_a[i] = 23'(Q + $urandom_range(0, 8190));
            if (i % 32 == 0) mem_b[i] = 23'h7FFFFF;
            exp_mem[i] = mod_mul(mem_a[i], mem_b[i]);
        end
    endtask

    initial begin
        int wen_n;
        int busy_n;

        vecs[0] = '{"ones",    23'd1,       23'd1,       23'd1};
        vecs[1] = '{"qm1",     23'd8380416, 23'd8380416, 23'd1};
        vecs[2] = '{"pow22",   23'd4194304, 23'd4194304, 23'd6297599};
        vecs[3] = '{"max_one", 23'd8388607, 23'd1,       23'd8190};
        vecs[4] = '{"max_max", 23'd8388607, 23'd8388607, 23'd32764};
        vecs[5] = '{"zero",    23'd0,       23'd8388607, 23'd0};
        vecs[6] = '{"q_five",  23'd8380417, 23'd5,       23'd0};

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end

        repeat (3) @(negedge clk);
        chk("reset wen", PWM_wen, 0);
        chk("reset wr_addr", PWM_wr_addr, 0);
        chk("reset dout", PWM_dout, 0);
        chk("reset rd_addr", PWM_rd_addr, 0);
        chk("reset busy", PWM_busy, 0);
        chk("reset done", PWM_done, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] = vecs[v].a;
                mem_b[i] = vecs[v].b;
                exp_mem[i] = vecs[v].c;
            end
            do_run(vecs[v].name, -1, -1);
        end

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 23'(i);
            mem_b[i] = 23'(i);
            exp_mem[i] = 23'(i * i);
        end
        do_run("ramp_pulsed", 10, 200);
        do_run("ramp_again", -1, -1);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            do_run($sformatf("random%0d", r), -1, -1);
        end

        fill_random();
        @(negedge clk);
        PWM_en = 1'b1;
        @(negedge clk);
        PWM_en = 1'b0;
        repeat (100) @(negedge clk);
        chk("midrun wen before reset", PWM_wen, 1);
        reset = 1'b0;
        #1;
        chk("midrun reset wen", PWM_wen, 0);
        chk("midrun reset busy", PWM_busy, 0);
        chk("midrun reset done", PWM_done, 0);
        chk("midrun reset rd_addr", PWM_rd_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        wen_n = 0;
        busy_n = 0;
        repeat (300) begin
            @(negedge clk);
            if (PWM_wen) wen_n++;
            if (PWM_busy) busy_n++;
        end
        chk("post reset writes", wen_n, 0);
        chk("post reset busy", busy_n, 0);
        do_run("after_reset", -1, -1);

        fill_random();
        @(negedge clk);
        PWM_en = 1'b1;
        for (int c = 0; c < 530; c++) begin
            @(negedge clk);
            if (c == 260) chk("held done@260", PWM_done, 1);
            if (c == 261) begin
                chk("held idle busy@261", PWM_busy, 0);
                chk("held idle done@261", PWM_done, 0);
            end
            if (c == 262) chk("held restart busy@262", PWM_busy, 1);
            if (c == 266) begin
                chk("held second wen@266", PWM_wen, 1);
                chk("held second addr@266", PWM_wr_addr, 0);
                chk("held second dout@266", PWM_dout, exp_mem[0]);
            end
            if (c == 270) PWM_en = 1'b0;
            if (c == 522) chk("held second done@522", PWM_done, 1);
            if (c == 523) chk("held second idle@523", PWM_busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
